sample_vector_seq: RTL and testbench
====================================

// Module: sample_vector_seq
// PURPOSE
//  Upstream stimulus stage and downstream signature stage for the gate/adder/dff sample netlist.
//  It issues a programmable-length run of LFSR-generated operand vectors to the sample block.
//  It captures the responses that come back after a fixed pipeline latency.
//  It compresses those responses into a 16-bit MISR signature for board-level EDIF sign-off.
// PARAMETERS
//  SEED      16'hACE1  LFSR load value on every start; must be nonzero
//  LEN_W     8         width of run-length input
//  RESP_LAT  1         cycles from vector issue to valid response; legal 0..8
// PORTS
//  clk_c1   in   1      clock; all state updates on posedge
//  rst_i1   in   1      reset; synchronous, active-high
//  start_i1 in   1      run request, sampled in IDLE or DONE only
//  len_i1   in   LEN_W  number of vectors per run, sampled with start_i1
//  resp_i1  in   8      adder result returned from sample block
//  resp_i2  in   1      one-bit gate result returned from sample block
//  add_o1   out  8      operand A = lfsr[7:0] while vld_o1, else 0
//  add_o2   out  8      operand B = lfsr[15:8] while vld_o1, else 0
//  gate_o1  out  2      gate operands = lfsr[1:0] while vld_o1, else 0
//  vld_o1   out  1      vector valid this cycle
//  busy_o1  out  1      high in RUN or DRAIN
//  done_o1  out  1      high in DONE, held until next start or reset
//  sig_o1   out  16     MISR signature
//  err_o1   out  8      mismatch count (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: state=IDLE; lfsr=SEED; count=0; sig=0; err=0; all outputs 0.
//  - FSM states: IDLE, RUN, DRAIN, DONE.
//    IDLE/DONE + start_i1 & len_i1!=0 -> RUN; lfsr<=SEED, sig<=0, err<=0, count<=len_i1.
//    IDLE/DONE + start_i1 & len_i1==0 -> DONE next cycle; sig=0.
//    RUN: vld_o1=1 each cycle; lfsr advances and count decrements after each issued vector.
//      When count reaches 1: RESP_LAT==0 -> DONE, else -> DRAIN.
//    DRAIN: hold RESP_LAT cycles with vld_o1=0, then -> DONE.
//  - LFSR step: lfsr <= {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
//    Operands are frozen outside RUN.
//  - Response capture: a RESP_LAT-deep valid shift register tracks vld_o1.
//    Response is captured when the delayed valid is 1; RESP_LAT==0 captures in the issue cycle.
//  - MISR: sig <= {sig[14:0], sig[15]^sig[13]^sig[12]^sig[10]} ^ {7'b0, resp_i2, resp_i1}.
//  - Exactly len_i1 responses are captured per run. Responses outside a run are ignored.
//  - start_i1 while busy_o1=1 is ignored.
//  - start_i1 in DONE restarts the run; done_o1 drops the next cycle.
//  - rst_i1 mid-run: abort to reset state next edge; pending responses are discarded.
//  - count is LEN_W bits with no wrap: a run issues exactly len_i1 vectors, max 2^LEN_W-1.
// CONFIGURATION
//  SEQ_CHECK_EN defined:
//    An internal model delays (add_o1+add_o2) mod 256 by RESP_LAT cycles.
//    It compares the delayed sum with resp_i1 on each capture.
//    err_o1 increments on each mismatch, saturating at 8'hFF, and clears on start.
//  SEQ_CHECK_EN undefined: no model logic; err_o1 tied to 0.
// TESTING
//  1 Reset asserted 3 cycles -> all outputs 0, state IDLE; start during reset ignored.
//  2 SEED=ACE1, len=3 -> vld_o1 high 3 cycles from start+1.
//    Vector 1: add_o1=E1, add_o2=AC. Vector 2: add_o1=C3, add_o2=59.
//  3 len=1, RESP_LAT=1, bench returns resp_i1=8D, resp_i2=0 -> sig_o1=008D and done_o1=1 at start+3.
//  4 len=0 -> done_o1=1 at start+1, vld_o1 never high, sig_o1=0000.
//  5 start pulsed mid-RUN -> ignored, vector count unchanged.
//    rst_i1 mid-RUN -> IDLE next edge, sig_o1=0.
//  6 SEQ_CHECK_EN, len=4, bench returns ~expected_sum -> err_o1=4.
//    Repeat with correct sums -> err_o1=0.

Source files
------------

// File: rtl/sample_vector_seq.sv
// LFSR stimulus issuer and MISR response compressor for the gate/adder/dff sample netlist.
// Optional build macro SEQ_CHECK_EN adds an adder reference model that counts response mismatches.
module sample_vector_seq #(
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int          LEN_W    = 8,
  parameter int          RESP_LAT = 1
) (
  input  logic             clk_c1,
  input  logic             rst_i1,
  input  logic             start_i1,
  input  logic [LEN_W-1:0] len_i1,
  input  logic [7:0]       resp_i1,
  input  logic             resp_i2,
  output logic [7:0]       add_o1,
  output logic [7:0]       add_o2,
  output logic [1:0]       gate_o1,
  output logic             vld_o1,
  output logic             busy_o1,
  output logic             done_o1,
  output logic [15:0]      sig_o1,
  output logic [7:0]       err_o1
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Response delay line needs at least one stage to declare even when RESP_LAT is 0.
  localparam int PD = (RESP_LAT == 0) ? 1 : RESP_LAT;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] v, input logic [7:0] r8,
                                            input logic r1);
    return lfsr_step(v) ^ {7'b0, r1, r8};
  endfunction

  state_t           state;
  logic [15:0]      lfsr;
  logic [15:0]      sig;
  logic [LEN_W-1:0] count;
  logic [3:0]       dcnt;
  logic             vld;
  logic             busy;
  logic             done;
  logic [PD-1:0]    vld_p1;
  logic             cap;
  logic             start_acc;

  assign start_acc = start_i1 && (state == IDLE || state == DONE);

  always_ff @(posedge clk_c1) begin
    if (rst_i1) begin
      state <= IDLE;
      lfsr  <= SEED;
      sig   <= '0;
      count <= '0;
      dcnt  <= '0;
      vld   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      if (cap)
        sig <= misr_step(sig, resp_i1, resp_i2);
      case (state)
        IDLE, DONE: begin
          if (start_acc) begin
            lfsr <= SEED;
            sig  <= '0;
            if (len_i1 != '0) begin
              state <= RUN;
              count <= len_i1;
              vld   <= 1'b1;
              busy  <= 1'b1;
              done  <= 1'b0;
            end else begin
              state <= DONE;
              count <= '0;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          lfsr  <= lfsr_step(lfsr);
          count <= count - LEN_W'(1);
          if (count == LEN_W'(1)) begin
            vld <= 1'b0;
            if (RESP_LAT == 0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= DRAIN;
              dcnt  <= 4'(RESP_LAT);
            end
          end
        end
        DRAIN: begin
          // Wait until the last issued vector's response has been captured.
          if (dcnt == 4'd1) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            dcnt <= dcnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stage p1..pN: valid delay line matching the sample block latency ----
  always_ff @(posedge clk_c1) begin
    if (rst_i1) begin
      vld_p1 <= '0;
    end else begin
      vld_p1[0] <= vld;
      for (int i = 1; i < PD; i++)
        vld_p1[i] <= vld_p1[i-1];
    end
  end

  assign cap = (RESP_LAT == 0) ? vld : vld_p1[PD-1];

  assign add_o1  = vld ? lfsr[7:0]  : 8'h00;
  assign add_o2  = vld ? lfsr[15:8] : 8'h00;
  assign gate_o1 = vld ? lfsr[1:0]  : 2'b00;
  assign vld_o1  = vld;
  assign busy_o1 = busy;
  assign done_o1 = done;
  assign sig_o1  = sig;

`ifdef SEQ_CHECK_EN
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [7:0] sum_p0;
  logic [7:0] sum_p1 [PD];
  logic [7:0] exp_sum;
  logic [7:0] err;

  assign sum_p0 = add_o1 + add_o2;

  // ---- stage p1..pN: reference sum travels beside the valid delay line ----
  always_ff @(posedge clk_c1) begin
    sum_p1[0] <= sum_p0;
    for (int i = 1; i < PD; i++)
      sum_p1[i] <= sum_p1[i-1];
  end

  assign exp_sum = (RESP_LAT == 0) ? sum_p0 : sum_p1[PD-1];

  always_ff @(posedge clk_c1) begin
    if (rst_i1)
      err <= '0;
    else if (start_acc)
      err <= '0;
    else if (cap && (resp_i1 != exp_sum))
      err <= sat_inc(err);
  end

  assign err_o1 = err;
`else
  assign err_o1 = 8'h00;
`endif

endmodule

// File: tb/tb_sample_vector_seq.sv
// Scoreboard bench for sample_vector_seq: expected vectors are queued at start, a monitor pops them.
module tb_sample_vector_seq;

  logic        clk_c1 = 1'b0;
  logic        rst_i1;
  logic        start_i1;
  logic [7:0]  len_i1;
  logic [7:0]  resp_i1;
  logic        resp_i2;
  logic [7:0]  add_o1;
  logic [7:0]  add_o2;
  logic [1:0]  gate_o1;
  logic        vld_o1;
  logic        busy_o1;
  logic        done_o1;
  logic [15:0] sig_o1;
  logic [7:0]  err_o1;

  always #5 clk_c1 = ~clk_c1;

  sample_vector_seq dut (
    .clk_c1(clk_c1), .rst_i1(rst_i1), .start_i1(start_i1), .len_i1(len_i1),
    .resp_i1(resp_i1), .resp_i2(resp_i2), .add_o1(add_o1), .add_o2(add_o2),
    .gate_o1(gate_o1), .vld_o1(vld_o1), .busy_o1(busy_o1), .done_o1(done_o1),
    .sig_o1(sig_o1), .err_o1(err_o1)
  );

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] g;
  } vec_t;

  // Hand-stepped LFSR states starting from the default seed.
  logic [15:0] lfsr_tab [8] = '{16'hACE1, 16'h59C3, 16'hB387, 16'h670F,
                                16'hCE1E, 16'h9C3C, 16'h3879, 16'h70F2};

  vec_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   vec_cnt = 0;
  int   resp_mode = 0;   // 0 correct sum, 1 inverted sum, 2 fixed value
  logic [7:0] fix_r1 = 8'h00;
  logic       fix_r2 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_vecs(input int n);
    vec_t v;
    for (int i = 0; i < n; i++) begin
      v.a = lfsr_tab[i][7:0];
      v.b = lfsr_tab[i][15:8];
      v.g = lfsr_tab[i][1:0];
      exp_q.push_back(v);
    end
  endtask

  // Issue a start and count cycles until done; optionally poke a second start mid-run.
  task automatic run(input int len, input int poke_at, output int lat);
    start_i1 = 1'b1;
    len_i1   = 8'(len);
    @(posedge clk_c1); #1;
    start_i1 = 1'b0;
    lat = 1;
    if (len != 0) begin
      check("done_drop", done_o1, 0);
      check("busy_rise", busy_o1, 1);
    end
    while (!done_o1 && lat < 600) begin
      if (lat == poke_at) begin
        start_i1 = 1'b1;
        len_i1   = 8'd2;
      end else begin
        start_i1 = 1'b0;
      end
      @(posedge clk_c1); #1;
      lat++;
    end
    start_i1 = 1'b0;
    if (!done_o1) check("done_timeout", done_o1, 1);
  endtask

  // Monitor: every valid vector must match the head of the expected queue.
  initial begin
    vec_t e;
    forever begin
      @(negedge clk_c1);
      if (vld_o1) begin
        vec_cnt++;
        if (exp_q.size() == 0) begin
          check("vec_unexpected_vld", vld_o1, 0);
        end else begin
          e = exp_q.pop_front();
          check("vec_add_a", add_o1, e.a);
          check("vec_add_b", add_o2, e.b);
          check("vec_gate", gate_o1, e.g);
        end
      end
    end
  end

  // Sample-block stand-in with one cycle latency; drives junk when nothing was issued.
  initial begin
    logic [7:0] nr1;
    logic       nr2;
    resp_i1 = 8'h00;
    resp_i2 = 1'b0;
    forever begin
      @(negedge clk_c1);
      if (vld_o1) begin
        case (resp_mode)
          0:       begin nr1 = add_o1 + add_o2;    nr2 = 1'b0;   end
          1:       begin nr1 = ~(add_o1 + add_o2); nr2 = 1'b0;   end
          default: begin nr1 = fix_r1;             nr2 = fix_r2; end
        endcase
      end else begin
        nr1 = 8'h5A;
        nr2 = 1'b1;
      end
      @(posedge clk_c1); #1;
      resp_i1 = nr1;
      resp_i2 = nr2;
    end
  end

  initial begin
    int lat;
    int base;
    rst_i1   = 1'b1;
    start_i1 = 1'b1;
    len_i1   = 8'd3;
    repeat (3) @(posedge clk_c1);
    #1;
    rst_i1   = 1'b0;
    start_i1 = 1'b0;
    check("rst_vld", vld_o1, 0);
    check("rst_busy", busy_o1, 0);
    check("rst_done", done_o1, 0);
    check("rst_sig", sig_o1, 16'h0000);
    check("rst_err", err_o1, 8'h00);
    check("rst_add", {add_o1, add_o2, gate_o1}, 18'h0);
    @(posedge clk_c1); #1;
    check("rst_start_ignored", busy_o1, 0);

    // Three-vector run with correct responses.
    push_vecs(3);
    run(3, 0, lat);
    check("len3_latency", lat, 5);
    check("len3_vecs", vec_cnt, 3);
    check("len3_sig", sig_o1, 16'h0236);
    check("len3_busy", busy_o1, 0);

    // Single vector, fixed response 8D.
    resp_mode = 2;
    fix_r1 = 8'h8D;
    fix_r2 = 1'b0;
    push_vecs(1);
    run(1, 0, lat);
    check("len1_latency", lat, 3);
    check("len1_sig", sig_o1, 16'h008D);
    check("len1_err", err_o1, 8'h00);

    // Restart from DONE with gate response bit set.
    fix_r2 = 1'b1;
    push_vecs(1);
    run(1, 0, lat);
    check("len1b_sig", sig_o1, 16'h018D);

    // Zero-length run.
    resp_mode = 0;
    base = vec_cnt;
    run(0, 0, lat);
    check("len0_latency", lat, 1);
    check("len0_sig", sig_o1, 16'h0000);
    check("len0_vecs", vec_cnt - base, 0);

    // Start pulsed mid-run must be ignored.
    base = vec_cnt;
    push_vecs(4);
    run(4, 2, lat);
    check("poke_latency", lat, 6);
    check("poke_vecs", vec_cnt - base, 4);
    check("poke_queue", exp_q.size(), 0);
    check("poke_sig", sig_o1, 16'h041A);

    // Inverted responses then correct ones.
    resp_mode = 1;
    push_vecs(4);
    run(4, 0, lat);
    check("inv_sig", sig_o1, 16'h011F);
`ifdef SEQ_CHECK_EN
    check("inv_err", err_o1, 8'd4);
`else
    check("inv_err", err_o1, 8'd0);
`endif
    resp_mode = 0;
    push_vecs(8);
    run(8, 0, lat);
    check("len8_latency", lat, 10);
    check("len8_sig", sig_o1, 16'h44AB);
    check("len8_err", err_o1, 8'd0);

    // Reset in the middle of a run.
    push_vecs(8);
    start_i1 = 1'b1;
    len_i1   = 8'd8;
    @(posedge clk_c1); #1;
    start_i1 = 1'b0;
    repeat (2) @(posedge clk_c1);
    #1;
    check("mid_busy_before", busy_o1, 1);
    rst_i1 = 1'b1;
    @(posedge clk_c1); #1;
    rst_i1 = 1'b0;
    check("midrst_vld", vld_o1, 0);
    check("midrst_busy", busy_o1, 0);
    check("midrst_done", done_o1, 0);
    check("midrst_sig", sig_o1, 16'h0000);
    exp_q.delete();
    repeat (3) @(posedge clk_c1);
    #1;
    check("midrst_idle_vld", vld_o1, 0);
    check("midrst_idle_sig", sig_o1, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
